// File: rtl/tinker_mem_if.sv
// Request/response channel between a Tinker core (master) and its memory target (slave).
// Both channels use valid/ready handshakes; only one transaction is ever outstanding.
interface tinker_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_size;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/tinker_mem_responder.sv
// Big-endian byte-addressed memory target for Tinker cores: 4-byte fetches, 8-byte loads/stores,
// each completed a fixed LATENCY cycles after acceptance, faulting on out-of-range or illegal accesses.
module tinker_mem_responder #(
    parameter int MEM_SIZE = 524288,
    parameter int LATENCY  = 2
) (
    input  logic         clk,
    input  logic         reset,
    tinker_mem_if.slave  bus
);
    localparam int         AW       = $clog2(MEM_SIZE);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic        write_reg;
    logic        size_reg;
    logic [63:0] addr_reg;
    logic [63:0] wdata_reg;
    logic        req_ready_reg;
    logic        resp_valid_reg;
    logic        resp_err_reg;
    logic [63:0] resp_rdata_reg;

    // Not reset: benches preload this array hierarchically.
    logic [7:0]  bytes [MEM_SIZE];

    // With LATENCY=1 the access runs on the accept edge, so it must use the live request.
    logic        op_write;
    logic        op_size;
    logic [63:0] op_addr;
    logic [63:0] op_wdata;

    assign op_write = (state_reg == IDLE) ? bus.req_write : write_reg;
    assign op_size  = (state_reg == IDLE) ? bus.req_size  : size_reg;
    assign op_addr  = (state_reg == IDLE) ? bus.req_addr  : addr_reg;
    assign op_wdata = (state_reg == IDLE) ? bus.req_wdata : wdata_reg;

    // A 65-bit sum catches wrap-around past the top of the 64-bit address space.
    logic [64:0] last_addr;
    logic        op_fault;

    assign last_addr = {1'b0, op_addr} + (op_size ? 65'd7 : 65'd3);
    assign op_fault  = last_addr[64]
                    || (last_addr[63:0] >= 64'(MEM_SIZE))
                    || (op_write && !op_size);

    logic [AW-1:0] lane_idx [8];
    logic [63:0]   rd8;
    logic [63:0]   rd_word;
    logic [63:0]   exec_rdata;

    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        assign lane_idx[gi]        = AW'(op_addr + 64'(gi));
        assign rd8[63-8*gi -: 8]   = bytes[lane_idx[gi]];
    end

    assign rd_word    = op_size ? rd8 : {32'b0, rd8[63:32]};
    assign exec_rdata = (op_fault || op_write) ? 64'b0 : rd_word;

    logic exec;
    logic commit;

    assign exec   = ((state_reg == IDLE) && bus.req_valid && (LATENCY == 1))
                 || ((state_reg == WAIT) && (cnt_reg == 4'd1));
    assign commit = exec && op_write && !op_fault;

    always_ff @(posedge clk) begin
        if (!reset && commit) begin
            for (int i = 0; i < 8; i++) begin
                bytes[lane_idx[i]] <= op_wdata[63-8*i -: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= 4'd0;
            write_reg      <= 1'b0;
            size_reg       <= 1'b0;
            addr_reg       <= 64'b0;
            wdata_reg      <= 64'b0;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= 64'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid) begin
                        write_reg     <= bus.req_write;
                        size_reg      <= bus.req_size;
                        addr_reg      <= bus.req_addr;
                        wdata_reg     <= bus.req_wdata;
                        cnt_reg       <= CNT_LOAD;
                        req_ready_reg <= 1'b0;
                        if (LATENCY == 1) begin
                            state_reg      <= RESP;
                            resp_valid_reg <= 1'b1;
                            resp_rdata_reg <= exec_rdata;
                            resp_err_reg   <= op_fault;
                        end else begin
                            state_reg <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        state_reg      <= RESP;
                        resp_valid_reg <= 1'b1;
                        resp_rdata_reg <= exec_rdata;
                        resp_err_reg   <= op_fault;
                    end
                end
                RESP: begin
                    // Returning to IDLE costs one cycle, so no accept overlaps the response handshake.
                    if (bus.resp_ready) begin
                        state_reg      <= IDLE;
                        resp_valid_reg <= 1'b0;
                        req_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    req_ready_reg  <= 1'b1;
                    resp_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_reg;
    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_rdata = resp_rdata_reg;
    assign bus.resp_err   = resp_err_reg;
endmodule

// File: tb/tb_tinker_mem_responder.sv
// Scoreboard bench for tinker_mem_responder: three instances with LATENCY 2, 4 and 1,
// driven by directed transactions whose responses are checked by an independent monitor.
module tb_tinker_mem_responder;
    localparam int MEM_SIZE = 524288;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [2:0]  req_valid_v, req_write_v, req_size_v, resp_ready_v;
    logic [2:0]  req_ready_v, resp_valid_v, resp_err_v;
    logic [63:0] req_addr_a  [3];
    logic [63:0] req_wdata_a [3];
    logic [63:0] resp_rdata_a [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int LAT = (gi == 0) ? 2 : ((gi == 1) ? 4 : 1);
        tinker_mem_if mif ();
        assign mif.req_valid     = req_valid_v[gi];
        assign mif.req_write     = req_write_v[gi];
        assign mif.req_size      = req_size_v[gi];
        assign mif.req_addr      = req_addr_a[gi];
        assign mif.req_wdata     = req_wdata_a[gi];
        assign mif.resp_ready    = resp_ready_v[gi];
        assign req_ready_v[gi]   = mif.req_ready;
        assign resp_valid_v[gi]  = mif.resp_valid;
        assign resp_err_v[gi]    = mif.resp_err;
        assign resp_rdata_a[gi]  = mif.resp_rdata;
        tinker_mem_responder #(.MEM_SIZE(MEM_SIZE), .LATENCY(LAT)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (mif)
        );
    end

    typedef struct {
        int          dut;
        logic [63:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t exp_q [$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 4 : 1);
    endfunction

    task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: measures latency from the accept cycle and compares every response handshake.
    logic [2:0] prev_valid = 3'b000;
    int         first_cyc [3];
    exp_t       mon_e;
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (resp_valid_v[d] === 1'b1 && prev_valid[d] !== 1'b1) first_cyc[d] = cyc;
            if (resp_valid_v[d] === 1'b1 && resp_ready_v[d] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp dut=%0d actual=valid required=no_response", d);
                end else begin
                    mon_e = exp_q.pop_front();
                    check64($sformatf("resp_dut dut=%0d", d), 64'(d), 64'(mon_e.dut));
                    check64($sformatf("resp_rdata dut=%0d", d), resp_rdata_a[d], mon_e.rdata);
                    check64($sformatf("resp_err dut=%0d", d), 64'(resp_err_v[d]), 64'(mon_e.err));
                    check64($sformatf("latency dut=%0d", d), 64'(first_cyc[d] - mon_e.acc), 64'(lat_of(d)));
                end
            end
            prev_valid[d] = resp_valid_v[d];
        end
    end

    // Presents a request (caller is just after a rising edge) and holds it until accepted.
    task automatic send(input int d, input logic w, input logic s, input logic [63:0] a,
                        input logic [63:0] wd, input logic [63:0] er, input logic ee,
                        input bit push, output int acc);
        exp_t e;
        req_write_v[d] = w;
        req_size_v[d]  = s;
        req_addr_a[d]  = a;
        req_wdata_a[d] = wd;
        req_valid_v[d] = 1'b1;
        acc = -1;
        for (int k = 0; k < 100 && acc < 0; k++) begin
            @(negedge clk);
            if (req_ready_v[d] === 1'b1) begin
                acc = cyc;
                if (push) begin
                    e.dut = d; e.rdata = er; e.err = ee; e.acc = cyc;
                    exp_q.push_back(e);
                end
            end
            @(posedge clk); #1;
        end
        if (acc < 0) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout dut=%0d actual=not_accepted required=accepted", d);
        end
        $display("txn dut=%0d write=%0b size=%0b addr=%h wdata=%h accept_cycle=%0d", d, w, s, a, wd, acc);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL resp_timeout actual=%0d_pending required=0_pending", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    int          acc;
    int          prev_acc;
    logic [63:0] b2b_addr [3];
    logic        b2b_size [3];
    logic [63:0] b2b_exp  [3];
    logic [63:0] mem8;

    initial begin
        reset        = 1'b1;
        req_valid_v  = 3'b000;
        req_write_v  = 3'b000;
        req_size_v   = 3'b000;
        resp_ready_v = 3'b111;
        for (int d = 0; d < 3; d++) begin
            req_addr_a[d]  = 64'b0;
            req_wdata_a[d] = 64'b0;
        end

        g_dut[0].dut.bytes[32'h2000] = 8'h12; g_dut[0].dut.bytes[32'h2001] = 8'h34;
        g_dut[0].dut.bytes[32'h2002] = 8'h56; g_dut[0].dut.bytes[32'h2003] = 8'h78;
        g_dut[0].dut.bytes[32'h2004] = 8'h9A; g_dut[0].dut.bytes[32'h2005] = 8'hBC;
        g_dut[0].dut.bytes[32'h2006] = 8'hDE; g_dut[0].dut.bytes[32'h2007] = 8'hF0;
        g_dut[0].dut.bytes[MEM_SIZE-4] = 8'hA1; g_dut[0].dut.bytes[MEM_SIZE-3] = 8'hA2;
        g_dut[0].dut.bytes[MEM_SIZE-2] = 8'hA3; g_dut[0].dut.bytes[MEM_SIZE-1] = 8'hA4;
        g_dut[0].dut.bytes[32'h100] = 8'h5A;
        for (int i = 0; i < 8; i++) g_dut[1].dut.bytes[32'h3000 + i] = 8'(8'h30 + i);
        for (int i = 0; i < 16; i++) g_dut[2].dut.bytes[32'h4000 + i] = 8'(i + 1);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check64($sformatf("reset_req_ready dut=%0d", d), 64'(req_ready_v[d]), 64'd1);
            check64($sformatf("reset_resp_valid dut=%0d", d), 64'(resp_valid_v[d]), 64'd0);
            check64($sformatf("reset_resp_err dut=%0d", d), 64'(resp_err_v[d]), 64'd0);
            check64($sformatf("reset_resp_rdata dut=%0d", d), resp_rdata_a[d], 64'd0);
        end
        @(posedge clk); #1;

        send(0, 1'b0, 1'b0, 64'h2000, 64'h0, 64'h0000_0000_1234_5678, 1'b0, 1'b1, acc);
        req_valid_v[0] = 1'b0; wait_idle();

        send(0, 1'b1, 1'b1, 64'h10000, 64'h0102_0304_0506_0708, 64'h0, 1'b0, 1'b1, acc);
        req_valid_v[0] = 1'b0; wait_idle();
        check64("mem_0x10000", 64'(g_dut[0].dut.bytes[32'h10000]), 64'h01);
        check64("mem_0x10007", 64'(g_dut[0].dut.bytes[32'h10007]), 64'h08);

        send(0, 1'b0, 1'b1, 64'h10000, 64'h0, 64'h0102_0304_0506_0708, 1'b0, 1'b1, acc);
        req_valid_v[0] = 1'b0; wait_idle();

        send(0, 1'b0, 1'b1, 64'(MEM_SIZE - 4), 64'h0, 64'h0, 1'b1, 1'b1, acc);
        req_valid_v[0] = 1'b0; wait_idle();

        send(0, 1'b0, 1'b0, 64'(MEM_SIZE - 4), 64'h0, 64'h0000_0000_A1A2_A3A4, 1'b0, 1'b1, acc);
        req_valid_v[0] = 1'b0; wait_idle();

        send(0, 1'b1, 1'b1, 64'(MEM_SIZE - 4), 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b1, acc);
        req_valid_v[0] = 1'b0; wait_idle();
        mem8 = {32'b0, g_dut[0].dut.bytes[MEM_SIZE-4], g_dut[0].dut.bytes[MEM_SIZE-3],
                g_dut[0].dut.bytes[MEM_SIZE-2], g_dut[0].dut.bytes[MEM_SIZE-1]};
        check64("mem_top_unchanged", mem8, 64'h0000_0000_A1A2_A3A4);

        send(0, 1'b1, 1'b0, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b1, acc);
        req_valid_v[0] = 1'b0; wait_idle();
        check64("mem_0x100_unchanged", 64'(g_dut[0].dut.bytes[32'h100]), 64'h5A);

        send(0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 64'h0, 1'b1, 1'b1, acc);
        req_valid_v[0] = 1'b0; wait_idle();

        // Back-pressure: hold the response for 5 cycles while offering another request.
        resp_ready_v[0] = 1'b0;
        send(0, 1'b0, 1'b1, 64'h2000, 64'h0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1, acc);
        req_valid_v[0] = 1'b0;
        for (int k = 0; k < 20 && resp_valid_v[0] !== 1'b1; k++) begin
            @(posedge clk); #1;
        end
        req_size_v[0]  = 1'b1;
        req_write_v[0] = 1'b0;
        req_addr_a[0]  = 64'h10000;
        req_valid_v[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check64("hold_resp_valid", 64'(resp_valid_v[0]), 64'd1);
            check64("hold_resp_rdata", resp_rdata_a[0], 64'h1234_5678_9ABC_DEF0);
            check64("hold_req_ready", 64'(req_ready_v[0]), 64'd0);
            @(posedge clk); #1;
        end
        req_valid_v[0]  = 1'b0;
        resp_ready_v[0] = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check64("after_hold_req_ready", 64'(req_ready_v[0]), 64'd1);
        check64("after_hold_resp_valid", 64'(resp_valid_v[0]), 64'd0);
        @(posedge clk); #1;
        wait_idle();

        // Reset two cycles after accepting a store on the LATENCY=4 instance.
        send(1, 1'b1, 1'b1, 64'h3000, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 1'b0, 1'b0, acc);
        req_valid_v[1] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check64("post_reset_req_ready", 64'(req_ready_v[1]), 64'd1);
        check64("post_reset_resp_valid", 64'(resp_valid_v[1]), 64'd0);
        repeat (6) @(posedge clk);
        #1;
        mem8 = {g_dut[1].dut.bytes[32'h3000], g_dut[1].dut.bytes[32'h3001],
                g_dut[1].dut.bytes[32'h3002], g_dut[1].dut.bytes[32'h3003],
                g_dut[1].dut.bytes[32'h3004], g_dut[1].dut.bytes[32'h3005],
                g_dut[1].dut.bytes[32'h3006], g_dut[1].dut.bytes[32'h3007]};
        check64("mem_0x3000_unchanged", mem8, 64'h3031_3233_3435_3637);

        send(1, 1'b0, 1'b1, 64'h3000, 64'h0, 64'h3031_3233_3435_3637, 1'b0, 1'b1, acc);
        req_valid_v[1] = 1'b0; wait_idle();

        // LATENCY=1 back-to-back reads with resp_ready held high.
        b2b_addr[0] = 64'h4000; b2b_size[0] = 1'b1; b2b_exp[0] = 64'h0102_0304_0506_0708;
        b2b_addr[1] = 64'h4008; b2b_size[1] = 1'b1; b2b_exp[1] = 64'h090A_0B0C_0D0E_0F10;
        b2b_addr[2] = 64'h4004; b2b_size[2] = 1'b0; b2b_exp[2] = 64'h0000_0000_0506_0708;
        prev_acc = 0;
        for (int i = 0; i < 3; i++) begin
            send(2, 1'b0, b2b_size[i], b2b_addr[i], 64'h0, b2b_exp[i], 1'b0, 1'b1, acc);
            if (i > 0) check64($sformatf("b2b_period idx=%0d", i), 64'(acc - prev_acc), 64'd2);
            prev_acc = acc;
        end
        req_valid_v[2] = 1'b0; wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
